// File: rtl/wrapper_bellek_if.sv
// Data-memory port of the memory stage.
//   master : the memory stage (drives the request, receives ready and response)
//   slave  : the data memory (receives the request, drives ready and response)
// Request channel : veri_istek_gecerli_o / veri_istek_hazir_i handshake carrying
//                   word address, write flag, byte mask and lane-steered write data.
// Response channel: veri_yanit_gecerli_i qualifies veri_yanit_veri_i (reads only).
interface wrapper_bellek_if;
  logic        veri_istek_gecerli_o;
  logic        veri_istek_hazir_i;
  logic [31:0] veri_istek_adres_o;
  logic        veri_istek_yaz_o;
  logic [3:0]  veri_istek_maske_o;
  logic [31:0] veri_istek_veri_o;
  logic        veri_yanit_gecerli_i;
  logic [31:0] veri_yanit_veri_i;

  modport master (
    output veri_istek_gecerli_o, veri_istek_adres_o, veri_istek_yaz_o,
           veri_istek_maske_o, veri_istek_veri_o,
    input  veri_istek_hazir_i, veri_yanit_gecerli_i, veri_yanit_veri_i
  );

  modport slave (
    input  veri_istek_gecerli_o, veri_istek_adres_o, veri_istek_yaz_o,
           veri_istek_maske_o, veri_istek_veri_o,
    output veri_istek_hazir_i, veri_yanit_gecerli_i, veri_yanit_veri_i
  );
endinterface

// File: rtl/wrapper_bellek.sv
// Memory stage. Takes the execute stage's memory/writeback bundle, performs
// loads/stores over the data-memory port and registers the result (or the
// pass-through ALU value) toward writeback. Stalls upstream while busy.
// Ports:
//   clk_i, rst_i (async, active-low), durdur_i (global freeze)
//   bellek_adresi_i, bellek_veri_i, load_save_buyrugu_i, bellekten_oku_i,
//   bellege_yaz_i, hedef_yazmac_verisi_i, yazmaca_yaz_i, hedef_yazmaci_i : from execute
//   veri          : data-memory port (wrapper_bellek_if.master)
//   bellek_stall_o: access in progress
//   hizasiz_o     : pulse, misaligned access dropped
//   zaman_asimi_o : pulse, watchdog abort
//   hedef_yazmac_verisi_o, yazmaca_yaz_o, hedef_yazmaci_o : toward writeback
module wrapper_bellek #(
  parameter int unsigned BEKLEME_SINIRI = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             durdur_i,
  input  logic [31:0]      bellek_adresi_i,
  input  logic [31:0]      bellek_veri_i,
  input  logic [2:0]       load_save_buyrugu_i,
  input  logic             bellekten_oku_i,
  input  logic             bellege_yaz_i,
  input  logic [31:0]      hedef_yazmac_verisi_i,
  input  logic             yazmaca_yaz_i,
  input  logic [4:0]       hedef_yazmaci_i,
  wrapper_bellek_if.master veri,
  output logic             bellek_stall_o,
  output logic             hizasiz_o,
  output logic             zaman_asimi_o,
  output logic [31:0]      hedef_yazmac_verisi_o,
  output logic             yazmaca_yaz_o,
  output logic [4:0]       hedef_yazmaci_o
);
  localparam int unsigned   SW       = $clog2(BEKLEME_SINIRI + 1);
  localparam logic [SW-1:0] SON_SAYI = SW'(BEKLEME_SINIRI - 1);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    BEKLE = 2'd2,
    TAMAM = 2'd3
  } durum_t;

  durum_t        durum, durum_sonraki;
  logic [SW-1:0] sayac;

  logic [31:0] op_adres, op_veri;
  logic [3:0]  op_maske;
  logic [1:0]  op_ofs;
  logic [2:0]  op_f3;
  logic        op_yaz, op_we;
  logic [4:0]  op_rd;

  logic [31:0] tampon_veri;
  logic        tampon_we;
  logic [4:0]  tampon_rd;

  logic        bellek_islemi, hizasiz;
  logic        yakala, hizasiz_atla, bitti, tamam_yaz, zaman_doldu, gecir;
  logic [31:0] sonuc_veri;
  logic        sonuc_we;

  // Store steering: {byte mask, write data}. funct3[1:0] selects the size;
  // anything not byte/half is treated as a word.
  function automatic logic [35:0] yaz_yonlendir(input logic [2:0] f3, input logic [1:0] ofs,
                                                input logic [31:0] d);
    logic [35:0] r;
    case (f3[1:0])
      2'b00:   r = {4'b0001 << ofs, {4{d[7:0]}}};
      2'b01:   r = {(ofs[1] ? 4'b1100 : 4'b0011), {2{d[15:0]}}};
      default: r = {4'b1111, d};
    endcase
    return r;
  endfunction

  // Load extraction: lane select plus sign/zero extension; undefined codes act as W.
  function automatic logic [31:0] yukle_cikar(input logic [2:0] f3, input logic [1:0] ofs,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{ofs, 3'b000} +: 8];
    h = ofs[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Decode of the incoming operation: memory op present and alignment check.
  always_comb begin
    bellek_islemi = bellekten_oku_i | bellege_yaz_i;
    if (load_save_buyrugu_i[1:0] == 2'b01) begin
      hizasiz = bellek_adresi_i[0];
    end else if (load_save_buyrugu_i[1] == 1'b1) begin
      hizasiz = (bellek_adresi_i[1:0] != 2'b00);
    end else begin
      hizasiz = 1'b0;
    end
  end

  // Completed access result; stores never write the register file.
  always_comb begin
    sonuc_veri = yukle_cikar(op_f3, op_ofs, veri.veri_yanit_veri_i);
    sonuc_we   = ~op_yaz & op_we;
  end

  // Next-state logic and one-cycle action strobes.
  always_comb begin
    durum_sonraki = durum;
    yakala        = 1'b0;
    hizasiz_atla  = 1'b0;
    bitti         = 1'b0;
    tamam_yaz     = 1'b0;
    zaman_doldu   = 1'b0;
    gecir         = 1'b0;
    case (durum)
      BOSTA: begin
        if (durdur_i) begin
          durum_sonraki = BOSTA;
        end else if (!bellek_islemi) begin
          gecir = 1'b1;
        end else if (hizasiz) begin
          hizasiz_atla = 1'b1;
        end else begin
          yakala        = 1'b1;
          durum_sonraki = ISTEK;
        end
      end
      ISTEK: begin
        // Acceptance wins over the watchdog so a completed handshake is never dropped.
        if (veri.veri_istek_hazir_i) begin
          if (op_yaz) begin
            bitti         = 1'b1;
            durum_sonraki = durdur_i ? TAMAM : BOSTA;
          end else begin
            durum_sonraki = BEKLE;
          end
        end else if (sayac == SON_SAYI) begin
          zaman_doldu   = 1'b1;
          durum_sonraki = BOSTA;
        end else begin
          durum_sonraki = ISTEK;
        end
      end
      BEKLE: begin
        if (veri.veri_yanit_gecerli_i) begin
          bitti         = 1'b1;
          durum_sonraki = durdur_i ? TAMAM : BOSTA;
        end else if (sayac == SON_SAYI) begin
          zaman_doldu   = 1'b1;
          durum_sonraki = BOSTA;
        end else begin
          durum_sonraki = BEKLE;
        end
      end
      TAMAM: begin
        if (!durdur_i) begin
          tamam_yaz     = 1'b1;
          durum_sonraki = BOSTA;
        end else begin
          durum_sonraki = TAMAM;
        end
      end
      default: durum_sonraki = BOSTA;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) durum <= BOSTA;
    else        durum <= durum_sonraki;
  end

  // Watchdog counter: restarts on issue, counts while the access is outstanding.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                 sayac <= '0;
    else if (yakala)                            sayac <= '0;
    else if (durum == ISTEK || durum == BEKLE)  sayac <= sayac + SW'(1);
    else                                        sayac <= sayac;
  end

  // Latched operation; request fields stay stable until accepted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_adres <= 32'd0;
      op_veri  <= 32'd0;
      op_maske <= 4'd0;
      op_ofs   <= 2'd0;
      op_f3    <= 3'd0;
      op_yaz   <= 1'b0;
      op_we    <= 1'b0;
      op_rd    <= 5'd0;
    end else if (yakala) begin
      op_adres <= {bellek_adresi_i[31:2], 2'b00};
      op_ofs   <= bellek_adresi_i[1:0];
      op_f3    <= load_save_buyrugu_i;
      op_yaz   <= bellege_yaz_i;
      op_we    <= yazmaca_yaz_i;
      op_rd    <= hedef_yazmaci_i;
      if (bellege_yaz_i) begin
        {op_maske, op_veri} <= yaz_yonlendir(load_save_buyrugu_i, bellek_adresi_i[1:0],
                                             bellek_veri_i);
      end else begin
        {op_maske, op_veri} <= {4'b1111, 32'd0};
      end
    end
  end

  // Result buffer used when completion coincides with a freeze.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tampon_veri <= 32'd0;
      tampon_we   <= 1'b0;
      tampon_rd   <= 5'd0;
    end else if (bitti && durdur_i) begin
      tampon_veri <= sonuc_veri;
      tampon_we   <= sonuc_we;
      tampon_rd   <= op_rd;
    end
  end

  // Writeback registers: pass-through, completion, buffered completion or bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hedef_yazmac_verisi_o <= 32'd0;
      yazmaca_yaz_o         <= 1'b0;
      hedef_yazmaci_o       <= 5'd0;
    end else if (gecir) begin
      hedef_yazmac_verisi_o <= hedef_yazmac_verisi_i;
      yazmaca_yaz_o         <= yazmaca_yaz_i;
      hedef_yazmaci_o       <= hedef_yazmaci_i;
    end else if (bitti && !durdur_i) begin
      hedef_yazmac_verisi_o <= sonuc_veri;
      yazmaca_yaz_o         <= sonuc_we;
      hedef_yazmaci_o       <= op_rd;
    end else if (tamam_yaz) begin
      hedef_yazmac_verisi_o <= tampon_veri;
      yazmaca_yaz_o         <= tampon_we;
      hedef_yazmaci_o       <= tampon_rd;
    end else if (yakala || hizasiz_atla || (zaman_doldu && !durdur_i)) begin
      yazmaca_yaz_o <= 1'b0;
    end
  end

  // Event pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hizasiz_o     <= 1'b0;
      zaman_asimi_o <= 1'b0;
    end else begin
      hizasiz_o     <= hizasiz_atla;
      zaman_asimi_o <= zaman_doldu;
    end
  end

  assign bellek_stall_o            = (durum != BOSTA);
  assign veri.veri_istek_gecerli_o = (durum == ISTEK);
  assign veri.veri_istek_adres_o   = op_adres;
  assign veri.veri_istek_yaz_o     = op_yaz;
  assign veri.veri_istek_maske_o   = op_maske;
  assign veri.veri_istek_veri_o    = op_veri;
endmodule

// File: tb/tb_wrapper_bellek.sv
// Self-checking bench for wrapper_bellek (watchdog limit 8). Expected values
// come from lane-level models of store steering and load extraction.
module tb_wrapper_bellek;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        durdur = 1'b0;
  logic [31:0] adr = 32'd0, wd = 32'd0, alu = 32'd0;
  logic [2:0]  buyruk = 3'd0;
  logic        oku = 1'b0, yaz = 1'b0, we_in = 1'b0;
  logic [4:0]  rd_in = 5'd0;
  logic        stall, hiz, zam, wb_we;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  int          n_vec = 0;
  int          n_err = 0;

  wrapper_bellek_if bus();

  wrapper_bellek #(.BEKLEME_SINIRI(8)) dut (
    .clk_i(clk), .rst_i(rst), .durdur_i(durdur),
    .bellek_adresi_i(adr), .bellek_veri_i(wd), .load_save_buyrugu_i(buyruk),
    .bellekten_oku_i(oku), .bellege_yaz_i(yaz),
    .hedef_yazmac_verisi_i(alu), .yazmaca_yaz_i(we_in), .hedef_yazmaci_i(rd_in),
    .veri(bus),
    .bellek_stall_o(stall), .hizasiz_o(hiz), .zaman_asimi_o(zam),
    .hedef_yazmac_verisi_o(wb_data), .yazmaca_yaz_o(wb_we), .hedef_yazmaci_o(wb_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sz_of(input logic [2:0] k);
    if (k[1:0] == 2'b00)      return 1;
    else if (k[1:0] == 2'b01) return 2;
    else                      return 4;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [2:0] k, input logic [31:0] a);
    int sz, off;
    logic [3:0] m;
    sz  = sz_of(k);
    off = (sz == 4) ? 0 : int'(a[1:0]);
    m   = 4'd0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] k, input logic [31:0] d);
    int sz;
    logic [31:0] r;
    sz = sz_of(k);
    r  = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] k, input logic [31:0] a,
                                           input logic [31:0] w);
    int sz, off;
    longint v;
    sz  = sz_of(k);
    off = (sz == 4) ? 0 : int'(a[1:0]);
    v   = 0;
    for (int i = 0; i < sz; i++) v += longint'(w[8*(off+i) +: 8]) << (8*i);
    if (sz < 4 && k[2] == 1'b0 && v >= (longint'(1) << (8*sz-1))) v -= (longint'(1) << (8*sz));
    return v[31:0];
  endfunction

  // One aligned access with rdy_wait cycles of hazir=0, resp_wait cycles before
  // the response, and hold cycles of freeze at completion.
  task automatic access(input logic st, input logic [2:0] k, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rw,
                        input int rdy_wait, input int resp_wait, input int hold);
    logic [4:0]  rdv;
    logic        wev;
    logic [3:0]  em;
    logic [31:0] ed;
    rdv = 5'($urandom_range(0, 31));
    wev = 1'($urandom_range(0, 1));
    em  = st ? exp_mask(k, a) : 4'hF;
    ed  = exp_wdata(k, d);
    adr = a; wd = d; buyruk = k; yaz = st;
    oku = st ? 1'($urandom_range(0, 1)) : 1'b1;
    alu = $urandom; we_in = wev; rd_in = rdv;
    tick();
    oku = 1'b0; yaz = 1'b0;
    chk("cap_stall", 32'(stall), 32'd1);
    chk("cap_bubble", 32'(wb_we), 32'd0);
    for (int i = 0; i <= rdy_wait; i++) begin
      bus.veri_istek_hazir_i   = (i == rdy_wait);
      bus.veri_yanit_gecerli_i = (i == rdy_wait) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.veri_yanit_veri_i    = $urandom;
      if (st && i == rdy_wait) durdur = (hold > 0);
      chk("req_valid", 32'(bus.veri_istek_gecerli_o), 32'd1);
      chk("req_addr", bus.veri_istek_adres_o, {a[31:2], 2'b00});
      chk("req_write", 32'(bus.veri_istek_yaz_o), 32'(st));
      chk("req_mask", 32'(bus.veri_istek_maske_o), 32'(em));
      if (st) chk("req_data", bus.veri_istek_veri_o, ed);
      chk("req_stall", 32'(stall), 32'd1);
      tick();
    end
    bus.veri_istek_hazir_i   = 1'b0;
    bus.veri_yanit_gecerli_i = 1'b0;
    if (!st) begin
      chk("wait_valid", 32'(bus.veri_istek_gecerli_o), 32'd0);
      for (int i = 0; i < resp_wait; i++) begin
        chk("wait_stall", 32'(stall), 32'd1);
        tick();
      end
      bus.veri_yanit_gecerli_i = 1'b1;
      bus.veri_yanit_veri_i    = rw;
      durdur = (hold > 0);
      chk("resp_stall", 32'(stall), 32'd1);
      tick();
      bus.veri_yanit_gecerli_i = 1'b0;
      bus.veri_yanit_veri_i    = $urandom;
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_stall", 32'(stall), 32'd1);
      chk("hold_we", 32'(wb_we), 32'd0);
      tick();
    end
    if (hold > 0) begin
      durdur = 1'b0;
      tick();
    end
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_valid", 32'(bus.veri_istek_gecerli_o), 32'd0);
    chk("done_we", 32'(wb_we), st ? 32'd0 : 32'(wev));
    if (!st) begin
      chk("done_data", wb_data, exp_load(k, a, rw));
      chk("done_rd", 32'(wb_rd), 32'(rdv));
    end
  endtask

  logic [2:0]  st_f3 [3] = '{3'b000, 3'b001, 3'b010};
  logic [2:0]  ld_f3 [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

  initial begin
    logic        st;
    logic [2:0]  k;
    logic [31:0] a;
    bus.veri_istek_hazir_i   = 1'b0;
    bus.veri_yanit_gecerli_i = 1'b0;
    bus.veri_yanit_veri_i    = 32'd0;

    // Reset state.
    tick(); tick();
    chk("rst_data", wb_data, 32'd0);
    chk("rst_we", 32'(wb_we), 32'd0);
    chk("rst_rd", 32'(wb_rd), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(bus.veri_istek_gecerli_o), 32'd0);
    chk("rst_pulses", {30'd0, hiz, zam}, 32'd0);
    rst = 1'b1;
    tick();

    // ALU pass-through.
    alu = 32'hDEADBEEF; we_in = 1'b1; rd_in = 5'd5;
    tick();
    chk("pt_data", wb_data, 32'hDEADBEEF);
    chk("pt_we", 32'(wb_we), 32'd1);
    chk("pt_rd", 32'(wb_rd), 32'd5);
    chk("pt_stall", 32'(stall), 32'd0);
    chk("pt_valid", 32'(bus.veri_istek_gecerli_o), 32'd0);

    // Freeze in idle: no capture, outputs hold.
    durdur = 1'b1; alu = 32'h12345678; we_in = 1'b0; rd_in = 5'd9; oku = 1'b1;
    buyruk = 3'b010; adr = 32'h100;
    tick();
    chk("frz_data", wb_data, 32'hDEADBEEF);
    chk("frz_rd", 32'(wb_rd), 32'd5);
    chk("frz_stall", 32'(stall), 32'd0);
    durdur = 1'b0; oku = 1'b0;

    for (int n = 0; n < 6; n++) begin
      alu = $urandom; we_in = 1'($urandom_range(0, 1)); rd_in = 5'($urandom_range(0, 31));
      tick();
      chk("rpt_data", wb_data, alu);
      chk("rpt_we", 32'(wb_we), 32'(we_in));
      chk("rpt_rd", 32'(wb_rd), 32'(rd_in));
    end

    // Directed store, loads and undefined funct3.
    access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'd0, 0, 0, 0);
    access(1'b0, 3'b000, 32'h0000_2001, 32'd0, 32'h0000_8000, 0, 2, 0);
    chk("lb_const", wb_data, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h0000_2001, 32'd0, 32'h0000_8000, 0, 2, 0);
    chk("lbu_const", wb_data, 32'h00000080);
    access(1'b0, 3'b001, 32'h0000_4002, 32'd0, 32'h8765_4321, 4, 0, 0);
    access(1'b0, 3'b011, 32'h0000_5000, 32'd0, 32'hCAFE_F00D, 1, 1, 0);
    access(1'b1, 3'b001, 32'h0000_6002, 32'h0000_BEEF, 32'd0, 2, 0, 2);
    access(1'b0, 3'b101, 32'h0000_7002, 32'd0, 32'hF234_5678, 0, 1, 3);

    // Misaligned word and half.
    adr = 32'h0000_2002; buyruk = 3'b010; oku = 1'b1;
    tick();
    oku = 1'b0;
    chk("mis_pulse", 32'(hiz), 32'd1);
    chk("mis_valid", 32'(bus.veri_istek_gecerli_o), 32'd0);
    chk("mis_we", 32'(wb_we), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    tick();
    chk("mis_pulse_end", 32'(hiz), 32'd0);
    adr = 32'h0000_3001; buyruk = 3'b001; yaz = 1'b1;
    tick();
    yaz = 1'b0;
    chk("mis_h_pulse", 32'(hiz), 32'd1);
    chk("mis_h_stall", 32'(stall), 32'd0);

    // Watchdog abort after 8 cycles without acceptance.
    tick();
    adr = 32'h0000_3000; buyruk = 3'b010; oku = 1'b1; we_in = 1'b1;
    tick();
    oku = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("wd_stall", 32'(stall), 32'd1);
      chk("wd_nopulse", 32'(zam), 32'd0);
      tick();
    end
    chk("wd_pulse", 32'(zam), 32'd1);
    chk("wd_stall_end", 32'(stall), 32'd0);
    chk("wd_valid_end", 32'(bus.veri_istek_gecerli_o), 32'd0);
    chk("wd_we", 32'(wb_we), 32'd0);
    tick();
    chk("wd_pulse_end", 32'(zam), 32'd0);

    // Reset in the middle of an access drops it.
    adr = 32'h0000_3100; buyruk = 3'b010; oku = 1'b1;
    tick();
    oku = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_stall", 32'(stall), 32'd0);
    chk("mrst_valid", 32'(bus.veri_istek_gecerli_o), 32'd0);
    rst = 1'b1;
    tick();
    chk("mrst_after", 32'(bus.veri_istek_gecerli_o), 32'd0);

    // Randomized aligned accesses.
    for (int n = 0; n < 24; n++) begin
      st = 1'($urandom_range(0, 1));
      k  = st ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 7)];
      a  = $urandom & ~32'(sz_of(k) - 1);
      access(st, k, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
